// File: rtl/sprite_fetch.sv
// Sprite texel address generator: latches sprite geometry at the start of each
// frame, detects in-box scan positions, and issues mirrored/scaled texel
// addresses to the pixel arbiter over a request/ack handshake.
module sprite_fetch #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned POS_W    = 10,
  parameter int unsigned STRIDE_W = 8,
  parameter int unsigned SCALE_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk25en,
  input  logic                sprite_enable,
  input  logic [POS_W-1:0]    x1_pos,
  input  logic [POS_W-1:0]    y1_pos,
  input  logic [POS_W-1:0]    x2_pos,
  input  logic [POS_W-1:0]    y2_pos,
  input  logic [ADDR_W-1:0]   address_in,
  input  logic [STRIDE_W-1:0] stride_in,
  input  logic [SCALE_W-1:0]  scale_in,
  input  logic                flip_x,
  input  logic                flip_y,
  input  logic [1:0]          layer_in,
  output logic [1:0]          layer_out,
  output logic [ADDR_W-1:0]   address_out,
  output logic                request,
  input  logic                ack,
  output logic                overrun,
  input  logic [POS_W-1:0]    curr_x_pos,
  input  logic [POS_W-1:0]    curr_y_pos,
  input  logic                blank
);

  // Shadow copies of the control inputs, refreshed only at scan position (0,0)
  logic [POS_W-1:0]    x1_q, y1_q, x2_q, y2_q;
  logic [ADDR_W-1:0]   base_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [SCALE_W-1:0]  scale_q;
  logic                flip_x_q, flip_y_q, spr_en_q;
  logic [1:0]          layer_q;

  // Stage 1 pipeline
  logic                hit_q, hit_d;
  logic                en_q;
  logic [POS_W-1:0]    col_q, col_d;
  logic [POS_W-1:0]    row_q, row_d;

  // Handshake / output state
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ovr_q, ovr_d;

  logic                frame_latch;
  logic                issue;
  logic [ADDR_W-1:0]   texel_addr;

  logic                in_x, in_y;
  logic [POS_W-1:0]    dx, dy, col_raw, row_raw, span_x, span_y;

  assign frame_latch = (curr_x_pos == '0) && (curr_y_pos == '0);

  // Frame latch of all control inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      base_q   <= '0;
      stride_q <= '0;
      scale_q  <= '0;
      flip_x_q <= 1'b0;
      flip_y_q <= 1'b0;
      spr_en_q <= 1'b0;
      layer_q  <= '0;
    end else if (frame_latch) begin
      x1_q     <= x1_pos;
      y1_q     <= y1_pos;
      x2_q     <= x2_pos;
      y2_q     <= y2_pos;
      base_q   <= address_in;
      stride_q <= stride_in;
      scale_q  <= scale_in;
      flip_x_q <= flip_x;
      flip_y_q <= flip_y;
      spr_en_q <= sprite_enable;
      layer_q  <= layer_in;
    end
  end

  // Stage 1: box hit test and scaled/mirrored texel column and row
  always_comb begin
    in_x    = (curr_x_pos >= x1_q) && (curr_x_pos <= x2_q);
    in_y    = (curr_y_pos >= y1_q) && (curr_y_pos <= y2_q);
    hit_d   = !blank && in_x && in_y;
    dx      = curr_x_pos - x1_q;
    dy      = curr_y_pos - y1_q;
    col_raw = dx >> scale_q;
    row_raw = dy >> scale_q;
    // Only meaningful on a hit, where x2 >= x1 and y2 >= y1
    span_x  = (x2_q - x1_q) >> scale_q;
    span_y  = (y2_q - y1_q) >> scale_q;
    col_d   = flip_x_q ? (span_x - col_raw) : col_raw;
    row_d   = flip_y_q ? (span_y - row_raw) : row_raw;
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      en_q  <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      hit_q <= hit_d;
      en_q  <= clk25en;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Residues mod 2^ADDR_W keep the product exact in the truncated result
  assign texel_addr = base_q + ADDR_W'(row_q) * ADDR_W'(stride_q) + ADDR_W'(col_q);
  assign issue      = en_q && hit_q && spr_en_q;

  // Stage 2: request/ack handshake, back-to-back issue and overrun tracking
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    ovr_d  = ovr_q;
    if (req_q && ack) begin
      req_d = 1'b0;
    end
    if (issue) begin
      if (!req_q || ack) begin
        req_d  = 1'b1;
        addr_d = texel_addr;
      end else begin
        // Arbiter still busy: drop this pixel, keep the pending address
        ovr_d = 1'b1;
      end
    end
    if (frame_latch) begin
      ovr_d = 1'b0;
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign request     = req_q;
  assign address_out = addr_q;
  assign overrun     = ovr_q;
  assign layer_out   = layer_q;

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
Parametrised next-generation sprite address generator. It sits between the VGA timing generator and the pixel arbiter. It latches sprite geometry once per frame and detects when the scan position is inside the sprite box. For each covered pixel it computes a texel address with stride, power-of-two scaling and X/Y mirroring, then issues it to the arbiter over a request/ack handshake, flagging overruns when the arbiter is slow.

Parameters:
ADDR_W, 16, width of sprite RAM address (MSBs select BRAM)
POS_W, 10, width of screen coordinates
STRIDE_W, 8, width of sprite row stride in texels
SCALE_W, 2, width of scale exponent (texel replicated 2^scale times in x and y)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
clk25en  in  1  one-cycle-in-four pixel clock enable
sprite_enable  in  1  show sprite
x1_pos, y1_pos, x2_pos, y2_pos  in  POS_W each  inclusive sprite box corners
address_in  in  ADDR_W  sprite base address
stride_in  in  STRIDE_W  texels per sprite row in RAM
scale_in  in  SCALE_W  scale exponent
flip_x, flip_y  in  1 each  horizontal / vertical mirror
layer_in  in  2  layer
layer_out  out  2  latched layer to arbiter
address_out  out  ADDR_W  requested texel address
request  out  1  request to arbiter, held until ack
ack  in  1  arbiter accepts current request
overrun  out  1  sticky: a pixel was dropped this frame
curr_x_pos, curr_y_pos  in  POS_W each  scan position
blank  in  1  1 = outside visible area

Behaviour:
- Reset (async, rst_n=0): all shadow registers, pipeline registers and outputs go to 0. Outputs: request=0, address_out=0, layer_out=0, overrun=0.
- Frame latch: on any clk with curr_x_pos==0 and curr_y_pos==0, copy all control inputs (including sprite_enable) into shadow registers and clear overrun. No other cycle changes the shadow registers.
- Stage 1 (every clk):
  - hit_q = visible && x1_s<=curr_x<=x2_s && y1_s<=curr_y<=y2_s, where visible = !blank.
  - dx = curr_x-x1_s; dy = curr_y-y1_s.
  - col = dx>>scale_s; row = dy>>scale_s.
  - If flip_x_s: col = ((x2_s-x1_s)>>scale_s) - col. flip_y is the same rule applied to rows.
  - en_q = clk25en.
- Stage 2 issue event: en_q && hit_q && sprite_enable_s.
  - addr = base_s + row*stride_s + col, truncated modulo 2^ADDR_W (wrap-around allowed).
- Latency: request rises 2 clk after the clk25en cycle in which the in-box position was presented.
- Handshake:
  - request stays 1 and address_out stays stable until ack=1 is sampled.
  - request falls the cycle after ack, unless a new issue event occurs in the ack cycle. In that case request stays 1 and address_out takes the new address (back-to-back).
  - ack while request=0 is ignored.
- Overrun: an issue event while request=1 and ack=0 drops the new pixel, keeps the pending address and sets overrun=1. overrun stays 1 until the next frame latch.
- Degenerate box (x2<x1 or y2<y1): no hits, no requests.
- Single-texel box (x1=x2, y1=y2): exactly one request per frame.
- layer_out = layer_s, driven combinationally from the shadow register.
- Control inputs changing mid-frame have no effect until the next frame latch.
- Reset mid-request: request drops immediately (async). After release, no request until a frame latch with sprite_enable=1.

Test Plan:
- Basic addressing: base=0x1000, stride=16, box x100..115 y50..65, scale 0, no flip. Pixels (100,50), (101,50), (100,51) -> addresses 0x1000, 0x1001, 0x1010. request asserts 2 clk after clk25en. With ack tied to 1: 16 requests per line, 256 per frame.
- Mirror: same setup with flip_x=1 -> (100,50) gives 0x100F. With flip_x=1 and flip_y=1 -> (115,65) gives 0x1000.
- Scale: scale=1, box x100..131 y50..81, stride 16. (103,52) -> 0x1011. Pixels (100,50) and (101,51) both -> 0x1000.
- Handshake and overrun: hold ack=0 across two in-box pixel events -> address_out keeps the first address and overrun=1. Assert ack -> request falls next clk. overrun clears at the next (0,0).
- Back-to-back and wrap: ack on the same cycle as the next issue -> request stays 1 with the new address. Base=0xFFFF, pixel 1 -> address 0x0000.
- Shadow and reset: change x1_pos mid-frame -> no effect until (0,0). Pulse rst_n=0 during request -> request=0 immediately. Degenerate box x2<x1 -> zero requests for a whole frame.
